// File: rtl/tile_pkg.sv
// Shared types and constants for the tile renderer: tile codes, RGB struct,
// palette, tank colours and the FSM state encoding.
package tile_pkg;

  // Number of map cells for a given grid size.
  function automatic int map_cells(input int cols, input int rows);
    return cols * rows;
  endfunction

  localparam int MAP_CELLS = map_cells(20, 15);

  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    WALL    = 3'd1,
    BRICK   = 3'd2,
    POWERUP = 3'd3,
    MINE    = 3'd4
  } tile_code_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK   = 24'h000000;
  localparam rgb_t RGB_WALL    = 24'h808080;
  localparam rgb_t RGB_BRICK   = 24'h964B00;
  localparam rgb_t RGB_POWERUP = 24'hFFD700;
  localparam rgb_t RGB_MINE    = 24'hC00000;

  // Tank i is drawn in TANK_COLOR[i]; lower index wins on overlap.
  localparam rgb_t TANK_COLOR [4] = '{
    rgb_t'(24'h005500),
    rgb_t'(24'h000055),
    rgb_t'(24'h550000),
    rgb_t'(24'h555500)
  };

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/tile_renderer_if.sv
// Map write port between game logic (master) and the tile renderer (slave).
interface tile_renderer_if #(
  parameter int CODE_W = 3
);
  logic              wr_en;
  logic [8:0]        wr_addr;
  logic [CODE_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/tile_map_ram.sv
// Single-clock simple dual-port tile map RAM with registered, read-first output.
module tile_map_ram #(
  parameter int DEPTH  = 300,
  parameter int WIDTH  = 3,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write and registered read share one edge; the read sees the pre-write contents.
  // NOTE: the array has no reset so it maps onto block RAM; the renderer's CLEAR pass initialises it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tile_renderer.sv
// Pipelined tile-map renderer: clears and owns the tile map, composites tank
// tiles over it and drives registered 24-bit RGB two clocks after sampling.
// Optional build macro: TILE_RENDERER_FLASH_EN (blinking power-up tiles).
module tile_renderer
  import tile_pkg::*;
#(
  parameter int TILE_SHIFT = 5,
  parameter int MAP_COLS   = 20,
  parameter int MAP_ROWS   = 15,
  parameter int NUM_TANKS  = 2,
  parameter int CODE_W     = 3
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic                   blank,
  input  logic                   frame_start,
  input  logic [10*NUM_TANKS-1:0] tank_x,
  input  logic [10*NUM_TANKS-1:0] tank_y,
  input  logic [NUM_TANKS-1:0]   tank_alive,
  tile_renderer_if.slave         wr_bus,
  output logic [7:0]             Red,
  output logic [7:0]             Green,
  output logic [7:0]             Blue
);

  localparam int              CELLS     = map_cells(MAP_COLS, MAP_ROWS);
  localparam int              AW        = 9;
  localparam int              TW        = 10 - TILE_SHIFT;
  localparam logic [9:0]      X_LIMIT   = 10'(MAP_COLS << TILE_SHIFT);
  localparam logic [9:0]      Y_LIMIT   = 10'(MAP_ROWS << TILE_SHIFT);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(CELLS - 1);
  localparam logic [AW:0]     CELLS_EXT = (AW + 1)'(CELLS);
  localparam logic [AW-1:0]   COLS_A    = AW'(MAP_COLS);

  // ---------------------------------------------------------------------------
  // Clear / run FSM
  // ---------------------------------------------------------------------------
  fsm_state_t    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          run;

  assign run = (state_q == ST_RUN);

  // Next state: walk every map address once, then accept game writes forever.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State register; reset restarts the clear pass from address 0.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign wr_bus.wr_ready = run;

  // ---------------------------------------------------------------------------
  // RAM write port: clear pass owns it in CLEAR, game logic in RUN
  // ---------------------------------------------------------------------------
  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [CODE_W-1:0] ram_wdata;

  // Select the write source; out-of-map game writes are silently dropped.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_cnt_q;
    ram_wdata = '0;
    if (!run) begin
      ram_we = 1'b1;
    end else if (wr_bus.wr_en && ({1'b0, wr_bus.wr_addr} < CELLS_EXT)) begin
      ram_we    = 1'b1;
      ram_waddr = wr_bus.wr_addr;
      ram_wdata = wr_bus.wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: tile index, blank and per-tank hit
  // ---------------------------------------------------------------------------
  logic [TW-1:0]        tile_col, tile_row;
  logic                 in_range;
  logic                 s1_valid_d, s1_valid_q;
  logic                 s1_blank_d, s1_blank_q;
  logic [NUM_TANKS-1:0] s1_hit_d, s1_hit_q;
  logic [AW-1:0]        s1_addr_d, s1_addr_q;

  assign tile_col = DrawX[9 -: TW];
  assign tile_row = DrawY[9 -: TW];
  assign in_range = (DrawX < X_LIMIT) && (DrawY < Y_LIMIT);

  // Compute the map address, effective blank and which tanks cover this tile.
  always_comb begin
    s1_valid_d = run;
    s1_blank_d = blank || !in_range;
    s1_addr_d  = in_range ? (AW'(tile_row) * COLS_A + AW'(tile_col)) : '0;
    s1_hit_d   = '0;
    for (int i = 0; i < NUM_TANKS; i++) begin
      s1_hit_d[i] = tank_alive[i]
                 && (tank_x[10*i+9 -: TW] == tile_col)
                 && (tank_y[10*i+9 -: TW] == tile_row);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 alignment: side-band travels beside the RAM read
  // ---------------------------------------------------------------------------
  logic                 s2_valid_q;
  logic                 s2_blank_q;
  logic [NUM_TANKS-1:0] s2_hit_q;
  logic [CODE_W-1:0]    rd_code;

  // Pipeline valid bits; data registers need no reset because valid qualifies them.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s1_valid_q;
    end
  end

  // Pipeline data registers for stage 1 and the stage-2 side-band.
  always_ff @(posedge Clk) begin
    s1_blank_q <= s1_blank_d;
    s1_hit_q   <= s1_hit_d;
    s1_addr_q  <= s1_addr_d;
    s2_blank_q <= s1_blank_q;
    s2_hit_q   <= s1_hit_q;
  end

  tile_map_ram #(
    .DEPTH  (CELLS),
    .WIDTH  (CODE_W),
    .ADDR_W (AW)
  ) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (s1_addr_q),
    .rdata (rd_code)
  );

  // ---------------------------------------------------------------------------
  // Optional power-up flashing
  // ---------------------------------------------------------------------------
  logic flash_off;

`ifdef TILE_RENDERER_FLASH_EN
  logic [4:0] frame_q, frame_d;

  // Count frames while running; the MSB blanks power-ups for half of every 32 frames.
  always_comb begin
    frame_d = frame_q;
    if (run && frame_start) begin
      frame_d = frame_q + 5'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign flash_off = frame_q[4];
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign flash_off          = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Stage 2: priority compositing and palette
  // ---------------------------------------------------------------------------
  logic [CODE_W-1:0] code_eff;
  logic              tank_hit;
  rgb_t              tank_rgb;
  rgb_t              rgb_d, rgb_q;

  // Blank > wall/brick > lowest-index tank > power-up/mine > background.
  always_comb begin
    code_eff = rd_code;
    if (flash_off && (rd_code == CODE_W'(POWERUP))) begin
      code_eff = CODE_W'(EMPTY);
    end

    tank_hit = 1'b0;
    tank_rgb = RGB_BLACK;
    for (int i = NUM_TANKS - 1; i >= 0; i--) begin
      if (s2_hit_q[i]) begin
        tank_hit = 1'b1;
        tank_rgb = TANK_COLOR[i];
      end
    end

    rgb_d = RGB_BLACK;
    if (!run || !s2_valid_q || s2_blank_q) begin
      rgb_d = RGB_BLACK;
    end else if (code_eff == CODE_W'(WALL)) begin
      rgb_d = RGB_WALL;
    end else if (code_eff == CODE_W'(BRICK)) begin
      rgb_d = RGB_BRICK;
    end else if (tank_hit) begin
      rgb_d = tank_rgb;
    end else if (code_eff == CODE_W'(POWERUP)) begin
      rgb_d = RGB_POWERUP;
    end else if (code_eff == CODE_W'(MINE)) begin
      rgb_d = RGB_MINE;
    end
  end

  // Registered pixel output.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rgb_q <= RGB_BLACK;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign Red   = rgb_q.r;
  assign Green = rgb_q.g;
  assign Blue  = rgb_q.b;

  // Sub-tile pixel bits only matter to the VGA path, not to tile lookup.
  logic unused_lsbs;
  assign unused_lsbs = ^{DrawX[TILE_SHIFT-1:0], DrawY[TILE_SHIFT-1:0], tank_x, tank_y};

endmodule

// File: tb/tb_tile_renderer.sv
// Self-checking bench for tile_renderer: directed cases plus randomized
// stimulus compared against a behavioural map/pixel model.
module tb_tile_renderer;

`ifdef TILE_RENDERER_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        blank = 1'b1;
  logic        frame_start = 1'b0;
  logic [19:0] tank_x = '0;
  logic [19:0] tank_y = '0;
  logic [1:0]  tank_alive = '0;
  logic [7:0]  Red, Green, Blue;

  tile_renderer_if #(.CODE_W(3)) wr_bus ();

  tile_renderer #(
    .TILE_SHIFT (5),
    .MAP_COLS   (20),
    .MAP_ROWS   (15),
    .NUM_TANKS  (2),
    .CODE_W     (3)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .frame_start (frame_start),
    .tank_x      (tank_x),
    .tank_y      (tank_y),
    .tank_alive  (tank_alive),
    .wr_bus      (wr_bus),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tile map array, clear countdown, frame count and the
  // two pixels in flight.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       blank;
    logic [1:0] hit;
    logic [9:0] idx;
  } pix_t;

  logic [2:0] m_map [300];
  int         m_clr   = 300;
  int         m_age   = 0;
  int         m_frame = 0;
  pix_t       p1 = '{blank: 1'b1, hit: 2'b00, idx: 10'd0};
  pix_t       p2 = '{blank: 1'b1, hit: 2'b00, idx: 10'd0};
  logic [2:0] c2 = 3'd0;

  function automatic pix_t observe();
    pix_t p;
    int x = int'(DrawX);
    int y = int'(DrawY);
    p.blank = blank || (x >= 640) || (y >= 480);
    for (int i = 0; i < 2; i++) begin
      int tx = int'(tank_x[10*i +: 10]);
      int ty = int'(tank_y[10*i +: 10]);
      p.hit[i] = tank_alive[i] && (tx / 32 == x / 32) && (ty / 32 == y / 32);
    end
    p.idx = 10'((y / 32) * 20 + x / 32);
    return p;
  endfunction

  function automatic logic [23:0] ref_color(input pix_t p, input logic [2:0] c, input int frame);
    if (p.blank) return 24'h000000;
    if (c == 3'd1) return 24'h808080;
    if (c == 3'd2) return 24'h964B00;
    if (p.hit[0]) return 24'h005500;
    if (p.hit[1]) return 24'h000055;
    if (c == 3'd3) return (FLASH && frame >= 16) ? 24'h000000 : 24'hFFD700;
    if (c == 3'd4) return 24'hC00000;
    return 24'h000000;
  endfunction

  // One clock: predict, let the edge happen, compare at the falling edge.
  task automatic cycle();
    bit          do_chk;
    logic [23:0] exp_rgb;
    logic        exp_ready;
    if (Reset || m_clr > 0) begin
      do_chk  = 1'b1;
      exp_rgb = 24'h000000;
    end else if (m_age >= 2) begin
      do_chk  = 1'b1;
      exp_rgb = ref_color(p2, c2, m_frame);
    end else begin
      do_chk  = 1'b0;
      exp_rgb = 24'h000000;
    end
    // The RAM read at this edge sees the map before this edge's write.
    c2 = (int'(p1.idx) < 300) ? m_map[p1.idx] : 3'd0;
    p2 = p1;
    p1 = observe();
    if (Reset) begin
      m_clr   = 300;
      m_age   = 0;
      m_frame = 0;
      for (int a = 0; a < 300; a++) m_map[a] = 3'd0;
    end else if (m_clr > 0) begin
      m_clr--;
    end else begin
      m_age++;
      if (wr_bus.wr_en && int'(wr_bus.wr_addr) < 300) m_map[wr_bus.wr_addr] = wr_bus.wr_data;
      if (frame_start) m_frame = (m_frame + 1) % 32;
    end
    exp_ready = (m_clr == 0);
    @(posedge Clk);
    @(negedge Clk);
    if (do_chk) check("rgb", {8'h00, Red, Green, Blue}, {8'h00, exp_rgb});
    check("wr_ready", {31'd0, wr_bus.wr_ready}, {31'd0, exp_ready});
  endtask

  task automatic settle();
    repeat (3) cycle();
  endtask

  task automatic set_pix(input int x, input int y, input logic b);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
  endtask

  task automatic write_tile(input int addr, input int data);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_addr = 9'(addr);
    wr_bus.wr_data = 3'(data);
    cycle();
    wr_bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_start = 1'b1;
      cycle();
      frame_start = 1'b0;
    end
  endtask

  task automatic count_clear(input string tag);
    int n = 0;
    while (wr_bus.wr_ready !== 1'b1 && n < 400) begin
      n++;
      cycle();
    end
    check(tag, n, 300);
  endtask

  function automatic logic [31:0] rgb_now();
    return {8'h00, Red, Green, Blue};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_bus.wr_en   = 1'b0;
    wr_bus.wr_addr = '0;
    wr_bus.wr_data = '0;

    // Reset state and clear length.
    Reset = 1'b1;
    cycle();
    check("rst_rgb", rgb_now(), 0);
    check("rst_ready", {31'd0, wr_bus.wr_ready}, 0);
    Reset = 1'b0;
    count_clear("clear_len");
    settle();

    // Fill the map with walls so the next clear is observable.
    for (int a = 0; a < 300; a++) write_tile(a, 1);
    set_pix(40, 40, 1'b0);
    settle();
    check("filled_wall", rgb_now(), 32'h808080);

    // Reset, then reset again mid-clear at count 150.
    set_pix(0, 0, 1'b1);
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    repeat (150) cycle();
    check("midclear_rgb", rgb_now(), 0);
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    count_clear("reclear_len");

    // Every tile reads code 0 after the clear.
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 20; c++) begin
        set_pix(c * 32 + int'($urandom_range(0, 31)), r * 32 + int'($urandom_range(0, 31)), 1'b0);
        cycle();
      end
    end
    settle();

    // Wall at tile 21 and two-cycle latency.
    write_tile(21, 1);
    set_pix(40, 40, 1'b1);
    settle();
    set_pix(40, 40, 1'b0);
    cycle();
    cycle();
    check("lat_prev_blank", rgb_now(), 0);
    cycle();
    check("wall_lat2", rgb_now(), 32'h808080);
    set_pix(40, 40, 1'b1);
    settle();
    check("blank_wall", rgb_now(), 0);
    set_pix(640, 40, 1'b0);
    settle();
    check("x_oob", rgb_now(), 0);
    set_pix(40, 480, 1'b0);
    settle();
    check("y_oob", rgb_now(), 0);

    // Tank priority.
    tank_x = {10'd0, 10'd40};
    tank_y = {10'd0, 10'd40};
    tank_alive = 2'b01;
    write_tile(21, 3);
    set_pix(40, 40, 1'b0);
    settle();
    check("tank_over_pwr", rgb_now(), 32'h005500);
    write_tile(21, 2);
    settle();
    check("brick_over_tank", rgb_now(), 32'h964B00);
    tank_x = {10'd45, 10'd40};
    tank_y = {10'd50, 10'd40};
    tank_alive = 2'b11;
    write_tile(21, 0);
    settle();
    check("tank0_wins", rgb_now(), 32'h005500);
    tank_alive = 2'b10;
    settle();
    check("tank1_only", rgb_now(), 32'h000055);
    tank_alive = 2'b00;

    // Read-first: write tile 5 on the same edge that reads it.
    set_pix(163, 5, 1'b0);
    settle();
    cycle();
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_addr = 9'd5;
    wr_bus.wr_data = 3'd4;
    cycle();
    wr_bus.wr_en   = 1'b0;
    cycle();
    check("rf_old", rgb_now(), 0);
    cycle();
    check("rf_new", rgb_now(), 32'hC00000);

    // Out-of-map write is dropped.
    write_tile(300, 1);
    set_pix(0, 0, 1'b0);
    settle();
    check("oob_wr_t0", rgb_now(), 0);
    set_pix(19 * 32, 14 * 32, 1'b0);
    settle();
    check("oob_wr_t299", rgb_now(), 0);

    // Power-up flashing.
    write_tile(21, 3);
    set_pix(40, 40, 1'b0);
    settle();
    check("pwr_f0", rgb_now(), 32'hFFD700);
    pulse_frames(15);
    settle();
    check("pwr_f15", rgb_now(), 32'hFFD700);
    pulse_frames(1);
    settle();
    check("pwr_f16", rgb_now(), FLASH ? 32'h000000 : 32'hFFD700);
    tank_alive = 2'b01;
    settle();
    check("pwr_f16_tank", rgb_now(), 32'h005500);
    tank_alive = 2'b00;
    pulse_frames(16);
    settle();
    check("pwr_f32", rgb_now(), 32'hFFD700);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        tank_x     = {10'($urandom_range(0, 639)), 10'($urandom_range(0, 639))};
        tank_y     = {10'($urandom_range(0, 479)), 10'($urandom_range(0, 479))};
        tank_alive = 2'($urandom);
      end
      if ($urandom % 3 == 0) begin
        int k = int'($urandom % 2);
        DrawX = tank_x[10*k +: 10];
        DrawY = tank_y[10*k +: 10];
      end else begin
        DrawX = 10'($urandom_range(0, 799));
        DrawY = 10'($urandom_range(0, 524));
      end
      blank          = ($urandom % 8 == 0);
      wr_bus.wr_en   = ($urandom % 4 == 0);
      wr_bus.wr_addr = 9'($urandom_range(0, 319));
      wr_bus.wr_data = 3'($urandom);
      frame_start    = ($urandom % 16 == 0);
      cycle();
    end
    wr_bus.wr_en = 1'b0;
    frame_start  = 1'b0;
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
